// File: rtl/scan_doubler_pkg.sv
// scan_doubler_pkg: constants, types and counter helpers shared by the line doubler
package scan_doubler_pkg;
    localparam int LINE_LEN_DEF = 448;
    localparam int PIX_W = 4;
    localparam int CNT_W = 9;
    localparam int RGBI_B = 0;
    localparam int RGBI_G = 1;
    localparam int RGBI_R = 2;
    localparam int RGBI_I = 3;
    typedef logic [PIX_W-1:0] pix_t;
    typedef logic [CNT_W-1:0] cnt_t;
    function automatic cnt_t sat_inc(cnt_t c, cnt_t last);
        return (c == last) ? c : c + 1'b1;
    endfunction
    function automatic cnt_t wrap_inc(cnt_t c, cnt_t last);
        return (c == last) ? '0 : c + 1'b1;
    endfunction
endpackage

// File: rtl/scan_doubler_line_buffer.sv
// line_buffer_dp: two-bank pixel line store, synchronous write, registered read
module line_buffer_dp
    import scan_doubler_pkg::*;
#(
    parameter int DEPTH = 2 * LINE_LEN_DEF,
    parameter int AW = CNT_W + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] waddr,
    input  logic [AW-1:0] raddr,
    input  pix_t          wdata,
    output pix_t          rdata
);
    pix_t mem [DEPTH];
    // store one pixel per write strobe; contents are never cleared
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end
    // output register doubles as pix_out, so it is the only part that resets
    always_ff @(posedge clk) begin
        if (rst) rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/scan_doubler.sv
// scan_doubler: 15.625 kHz RGBI to 31.25 kHz VGA line doubler on the 28 MHz clock
module scan_doubler
    import scan_doubler_pkg::*;
#(
    parameter int LINE_LEN = LINE_LEN_DEF,
    parameter int HS_START = 0,
    parameter int HS_LEN = 56,
    parameter bit SYNC_NEG = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce_in,
    input  logic             ce_out,
    input  logic [PIX_W-1:0] pix_in,
    input  logic             hsync_in,
    input  logic             vsync_in,
    output logic [PIX_W-1:0] pix_out,
    output logic             vga_hsync,
    output logic             vga_vsync,
    output logic             wbank
);
    localparam int AW = CNT_W + 1;
    localparam cnt_t LAST = cnt_t'(LINE_LEN - 1);
    cnt_t hin, hout, win;
    logic hs_q, line_start, wb_eff, hs_act;
    logic [AW-1:0] waddr, raddr;
    assign line_start = ce_in & hsync_in & ~hs_q;
    assign wb_eff = wbank ^ line_start;
    assign win = line_start ? '0 : hin;
    assign waddr = wb_eff ? AW'(LINE_LEN) + AW'(win) : AW'(win);
    assign raddr = wb_eff ? AW'(hout) : AW'(LINE_LEN) + AW'(hout);
    assign hs_act = int'(hout) >= HS_START && int'(hout) < HS_START + HS_LEN;
    // write/read counters and bank toggle; a line start overrides the hout wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            hs_q <= 1'b0;
            hin <= '0;
            hout <= '0;
            wbank <= 1'b0;
        end else begin
            if (ce_in) begin
                hs_q <= hsync_in;
                hin <= sat_inc(win, LAST);
            end
            if (line_start) begin
                wbank <= ~wbank;
                hout <= '0;
            end else if (ce_out) begin
                hout <= wrap_inc(hout, LAST);
            end
        end
    end
    // VGA syncs registered on ce_out so they line up with pix_out
    always_ff @(posedge clk) begin
        if (rst) begin
            vga_hsync <= SYNC_NEG;
            vga_vsync <= SYNC_NEG;
        end else if (ce_out) begin
            vga_hsync <= hs_act ^ SYNC_NEG;
            vga_vsync <= vsync_in ^ SYNC_NEG;
        end
    end
    line_buffer_dp #(.DEPTH(2 * LINE_LEN), .AW(AW)) u_buf (
        .clk(clk),
        .rst(rst),
        .we(ce_in & ~rst),
        .re(ce_out),
        .waddr(waddr),
        .raddr(raddr),
        .wdata(pix_in),
        .rdata(pix_out)
    );
endmodule

// File: tb/tb_scan_doubler.sv
// tb_scan_doubler: random line stimulus checked against a line-level reference model
module tb_scan_doubler;
    localparam int L = 448;
    localparam int HS_START = 0;
    localparam int HS_LEN = 56;
    logic clk = 1'b0;
    logic rst = 1'b1, ce_in = 1'b0, ce_out = 1'b0, hsync_in = 1'b0, vsync_in = 1'b0;
    logic [3:0] pix_in = 4'h0, pix_out;
    logic vga_hsync, vga_vsync, wbank;
    int errors = 0, checks = 0, ph = 0;
    logic [3:0] prev_line [L], cur_line [L], tmp_line [L];
    bit prev_ok [L], cur_ok [L], tmp_ok [L];
    int wpos = 0, rpos = 0;
    logic m_bank = 1'b0, m_hsq = 1'b0, e_hs = 1'b1, e_vs = 1'b1;
    logic [3:0] e_pix = 4'h0;
    bit e_ok = 1'b1;

    scan_doubler dut (
        .clk(clk), .rst(rst), .ce_in(ce_in), .ce_out(ce_out), .pix_in(pix_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .pix_out(pix_out),
        .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .wbank(wbank)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // expected outputs after the coming edge: the last completed input line is
    // replayed by output position, the line in progress is captured by write position
    task automatic model();
        logic edge_seen;
        if (rst) begin
            foreach (prev_ok[i]) begin prev_ok[i] = 0; cur_ok[i] = 0; end
            wpos = 0; rpos = 0; m_bank = 0; m_hsq = 0;
            e_pix = 4'h0; e_ok = 1; e_hs = 1; e_vs = 1;
        end else begin
            edge_seen = ce_in && hsync_in && !m_hsq;
            if (ce_in) m_hsq = hsync_in;
            if (edge_seen) begin
                tmp_line = prev_line; tmp_ok = prev_ok;
                prev_line = cur_line; prev_ok = cur_ok;
                cur_line = tmp_line; cur_ok = tmp_ok;
                m_bank = ~m_bank; wpos = 0;
            end
            if (ce_out) begin
                e_pix = prev_line[rpos]; e_ok = prev_ok[rpos];
                e_hs = !(rpos >= HS_START && rpos < HS_START + HS_LEN);
                e_vs = !vsync_in;
                rpos = edge_seen ? 0 : (rpos + 1) % L;
            end
            if (ce_in) begin
                cur_line[wpos] = pix_in; cur_ok[wpos] = 1;
                wpos = (wpos == L - 1) ? wpos : wpos + 1;
            end
        end
    endtask

    task automatic step();
        ce_in = (ph == 0);
        ce_out = (ph % 2 == 0);
        model();
        @(posedge clk);
        #1;
        ph = (ph + 1) % 4;
        if (e_ok) check("pix_out", pix_out, e_pix);
        check("vga_hsync", vga_hsync, e_hs);
        check("vga_vsync", vga_vsync, e_vs);
        check("wbank", wbank, m_bank);
    endtask

    // mode 0 ramp, 1 constant, 2 random; rst_at holds rst for 3 clk at that pixel
    task automatic run_line(input int len, input bit sync, input bit vs, input int mode,
                            input logic [3:0] val, input int rst_at);
        for (int p = 0; p < len; p++) begin
            hsync_in = sync && p < 28;
            vsync_in = vs;
            pix_in = (mode == 0) ? p[3:0] : (mode == 1) ? val : 4'($urandom);
            for (int c = 0; c < 4; c++) begin
                rst = (p == rst_at && c < 3);
                step();
            end
        end
    endtask

    initial begin
        run_line(20, 0, 0, 2, 4'h0, 0);
        run_line(L, 1, 0, 0, 4'h0, -1);
        repeat (2) run_line(L, 1, 0, 2, 4'h0, -1);
        run_line(L, 1, 0, 1, 4'hA, -1);
        run_line(L, 1, 0, 1, 4'h5, -1);
        run_line(L, 1, 0, 1, 4'hA, -1);
        repeat (3) run_line(L, 0, 0, 2, 4'h0, -1);
        repeat (2) run_line(L, 1, 0, 2, 4'h0, -1);
        repeat (4) run_line(int'($urandom_range(430, 470)), 1, 0, 2, 4'h0, -1);
        repeat (8) run_line(L, 1, 1, 2, 4'h0, -1);
        repeat (2) run_line(L, 1, 0, 2, 4'h0, -1);
        run_line(L, 1, 0, 2, 4'h0, 200);
        repeat (2) run_line(L, 1, 0, 2, 4'h0, -1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
